xif_result_arbiter: RTL and testbench

XIF_RESULT_ARBITER -- requirements
Module: xif_result_arbiter

---
 rtl/xif_result_arbiter.sv | 111 +++++++++++
 tb/tb_xif_result_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/xif_result_arbiter.sv
// Round-robin arbiter merging NUM_REQ coprocessor result channels into one registered CPU result slot.
// Latency: one cycle from requester handshake to out_valid_o; one result per cycle sustained.
// Backpressure: req_ready_o is all-zero while the slot is full and the CPU stalls, and during reset.
module xif_result_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    localparam int RES_W      = X_ID_WIDTH + X_RFW_WIDTH + 13,
    localparam int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*RES_W-1:0] req_result_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [RES_W-1:0]         out_result_o,
    output logic [SRC_W-1:0]         out_src_o
);

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
        logic                   exc;
        logic [5:0]             exccode;
    } res_t;

    res_t             chan_res [NUM_REQ];
    res_t             out_result_q, out_result_d;
    logic             out_valid_q, out_valid_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;
    logic [SRC_W-1:0] prio_q, prio_d;

    logic             can_load;
    logic             grant_vld;
    logic [SRC_W-1:0] grant_idx;
    logic             load;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_chan
        assign chan_res[k] = res_t'(req_result_i[k*RES_W +: RES_W]);
    end

    assign can_load = !out_valid_q || out_ready_i;

    // Rotating scan starting at prio_q; cand wraps explicitly so non-power-of-two NUM_REQ works.
    always_comb begin
        int               cand;
        logic [SRC_W-1:0] cand_idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(prio_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = SRC_W'(cand);
            if (!grant_vld && req_valid_i[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign load = grant_vld && can_load && !rst;

    always_comb begin
        req_ready_o = '0;
        if (load) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_src_d    = out_src_q;
        prio_d       = prio_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_result_d = chan_res[grant_idx];
            out_src_d    = grant_idx;
            prio_d       = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_src_q    <= '0;
            prio_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_src_q    <= out_src_d;
            prio_q       <= prio_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_result_o = out_result_q;
    assign out_src_o    = out_src_q;

endmodule

// File: tb/tb_xif_result_arbiter.sv
// Bench for xif_result_arbiter: directed scenarios followed by randomized traffic against a behavioural model.
module tb_xif_result_arbiter;
    localparam int N   = 4;
    localparam int IDW = 4;
    localparam int RFW = 32;
    localparam int RW  = IDW + RFW + 13;
    localparam int SW  = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  vld;
    logic [N-1:0]  rdy;
    logic [N*RW-1:0] pay;
    logic          ov;
    logic          ordy;
    logic [RW-1:0] ores;
    logic [SW-1:0] osrc;

    int checks   = 0;
    int failures = 0;

    // Model state: what the output slot should hold and whose turn it is.
    logic          m_valid;
    logic [RW-1:0] m_res;
    int            m_src;
    int            m_ptr;

    always #5 clk = ~clk;

    xif_result_arbiter #(.NUM_REQ(N), .X_ID_WIDTH(IDW), .X_RFW_WIDTH(RFW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (vld),
        .req_ready_o  (rdy),
        .req_result_i (pay),
        .out_valid_o  (ov),
        .out_ready_i  (ordy),
        .out_result_o (ores),
        .out_src_o    (osrc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] chan(input int k);
        return pay[k*RW +: RW];
    endfunction

    // First valid channel in round-robin order from m_ptr, or -1.
    function automatic int pick(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic rand_payload();
        for (int k = 0; k < N; k++) begin
            pay[k*RW +: RW] = {$urandom, $urandom};
        end
    endtask

    // Apply inputs, check the cycle against the model, then advance both across one edge.
    task automatic cyc(input logic r, input logic [N-1:0] v, input logic o);
        int g;
        logic [N-1:0] er;
        logic can;
        rst  = r;
        vld  = v;
        ordy = o;
        @(negedge clk);
        g   = pick(v);
        can = !m_valid || o;
        er  = '0;
        if (!r && g >= 0 && can) er[g] = 1'b1;
        chk("req_ready", rdy, er);
        chk("out_valid", ov, m_valid);
        chk("out_result", ores, m_res);
        chk("out_src", osrc, m_src);
        if (r) begin
            m_valid = 1'b0; m_res = '0; m_src = 0; m_ptr = 0;
        end else if (g >= 0 && can) begin
            m_valid = 1'b1; m_res = chan(g); m_src = g; m_ptr = (g + 1) % N;
        end else if (m_valid && o) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [RW-1:0] held;
        rst = 1'b1; vld = '0; ordy = 1'b0;
        rand_payload();
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_valid = 1'b0; m_res = '0; m_src = 0; m_ptr = 0;

        // Reset state, idle
        cyc(1'b0, 4'b0000, 1'b1);
        chk("idle_valid", ov, 1'b0);

        // All channels valid with sink always ready: grants rotate 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            cyc(1'b0, 4'b1111, 1'b1);
            chk("rr_src", osrc, i % N);
            chk("rr_valid", ov, 1'b1);
        end
        cyc(1'b0, 4'b0000, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);
        chk("drain_valid", ov, 1'b0);

        // Single channel 2 with stalled sink, then release
        pay[2*RW +: RW] = {4'd5, 32'hDEADBEEF, 13'h0};
        cyc(1'b0, 4'b0100, 1'b0);
        chk("stall_src", osrc, 2);
        chk("stall_id", ores[RW-1 -: IDW], 5);
        held = ores;
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            cyc(1'b0, 4'b0100, 1'b0);
            chk("stall_hold", ores, held);
        end
        cyc(1'b0, 4'b0000, 1'b1);
        chk("release_valid", ov, 1'b0);

        // Pointer now 3: channel 3 then 0 with wraparound
        rand_payload();
        cyc(1'b0, 4'b1001, 1'b1);
        chk("wrap_src3", osrc, 3);
        cyc(1'b0, 4'b1001, 1'b1);
        chk("wrap_src0", osrc, 0);
        // Back-to-back replacement from channel 1
        cyc(1'b0, 4'b0010, 1'b1);
        chk("replace_src", osrc, 1);
        chk("replace_valid", ov, 1'b1);

        // Reset while holding a stalled result
        cyc(1'b0, 4'b0100, 1'b0);
        cyc(1'b1, 4'b0100, 1'b0);
        chk("rst_valid", ov, 1'b0);
        chk("rst_src", osrc, 0);
        cyc(1'b0, 4'b0100, 1'b1);
        chk("post_rst_src", osrc, 2);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rand_payload();
            cyc(($urandom_range(0, 49) == 0), N'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
